// File: rtl/pipelined_barrel_shifter_if.sv
// rtl/pipelined_barrel_shifter_if.sv - operand/result handshake bundle for pipelined_barrel_shifter
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int LW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LW-1:0]    in_amt;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_sticky;

    modport master (
        output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_sticky
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_sticky
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - pipelined SLL/SRL/SRA/ROL/ROR shifter with tag and valid/ready
// Optional sticky (OR of discarded bits) built when PIPELINED_BARREL_SHIFTER_STICKY_EN is defined.
module pipelined_barrel_shifter #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int LW = $clog2(WIDTH);

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    // First mux level handled by stage s; earlier stages absorb the remainder.
    function automatic int lvl_lo(input int s);
        return s * (LW / STAGES) + ((s < (LW % STAGES)) ? s : (LW % STAGES));
    endfunction

    function automatic logic [WIDTH-1:0] shift_lvl(input logic [WIDTH-1:0] d,
                                                    input logic [2:0] o, input int l);
        int sh;
        sh = 1 << l;
        case (o)
            OP_SLL:  return d << sh;
            OP_SRL:  return d >> sh;
            OP_SRA:  return WIDTH'($signed(d) >>> sh);
            OP_ROL:  return (d << sh) | (d >> (WIDTH - sh));
            OP_ROR:  return (d >> sh) | (d << (WIDTH - sh));
            default: return d;
        endcase
    endfunction

`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
    function automatic logic lost_lvl(input logic [WIDTH-1:0] d,
                                      input logic [2:0] o, input int l);
        int sh;
        sh = 1 << l;
        case (o)
            OP_SLL:         return |(d >> (WIDTH - sh));
            OP_SRL, OP_SRA: return |(d << (WIDTH - sh));
            default:        return 1'b0;
        endcase
    endfunction
`endif

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [LW-1:0]     r_amt  [STAGES];
    logic [2:0]        r_op   [STAGES];
    logic [TAG_W-1:0]  r_tag  [STAGES];

    logic [STAGES-1:0] w_rdy;
    logic [STAGES-1:0] w_vin;
    logic [WIDTH-1:0]  w_din  [STAGES];
    logic [LW-1:0]     w_ain  [STAGES];
    logic [2:0]        w_oin  [STAGES];
    logic [TAG_W-1:0]  w_tin  [STAGES];
    logic [WIDTH-1:0]  w_nd   [STAGES];
    logic              w_pass;

`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
    logic [STAGES-1:0] r_sticky;
    logic [STAGES-1:0] w_sin;
    logic [STAGES-1:0] w_ns;
`endif

    // A stage may load when it is empty or some later stage (or the sink) frees a slot.
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            w_rdy[s] = bus.out_ready;
            for (int j = s; j < STAGES; j++) begin
                if (!r_valid[j]) w_rdy[s] = 1'b1;
            end
        end
    end

    assign w_pass = (bus.in_op > OP_ROR);

    always_comb begin
        w_vin[0] = bus.in_valid;
        w_din[0] = bus.in_data;
        w_ain[0] = w_pass ? '0 : bus.in_amt;
        w_oin[0] = w_pass ? OP_SLL : bus.in_op;
        w_tin[0] = bus.in_tag;
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
        w_sin[0] = 1'b0;
`endif
        for (int s = 1; s < STAGES; s++) begin
            w_vin[s] = r_valid[s-1];
            w_din[s] = r_data[s-1];
            w_ain[s] = r_amt[s-1];
            w_oin[s] = r_op[s-1];
            w_tin[s] = r_tag[s-1];
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
            w_sin[s] = r_sticky[s-1];
`endif
        end
        for (int s = 0; s < STAGES; s++) begin
            w_nd[s] = w_din[s];
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
            w_ns[s] = w_sin[s];
`endif
            for (int l = 0; l < LW; l++) begin
                if (l >= lvl_lo(s) && l < lvl_lo(s + 1) && w_ain[s][l]) begin
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
                    w_ns[s] = w_ns[s] | lost_lvl(w_nd[s], w_oin[s], l);
`endif
                    w_nd[s] = shift_lvl(w_nd[s], w_oin[s], l);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_data[s] <= '0;
                r_amt[s]  <= '0;
                r_op[s]   <= '0;
                r_tag[s]  <= '0;
            end
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
            r_sticky <= '0;
`endif
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (w_rdy[s]) begin
                    r_valid[s] <= w_vin[s];
                    if (w_vin[s]) begin
                        r_data[s] <= w_nd[s];
                        r_amt[s]  <= w_ain[s];
                        r_op[s]   <= w_oin[s];
                        r_tag[s]  <= w_tin[s];
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
                        r_sticky[s] <= w_ns[s];
`endif
                    end
                end
            end
        end
    end

    assign bus.in_ready  = w_rdy[0];
    assign bus.out_valid = r_valid[STAGES-1];
    assign bus.out_data  = r_data[STAGES-1];
    assign bus.out_tag   = r_tag[STAGES-1];
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
    assign bus.out_sticky = r_sticky[STAGES-1];
`else
    assign bus.out_sticky = 1'b0;
`endif
endmodule
